// File: rtl/barrett_reduce_pipe_if.sv
// Operand/result stream bundle for the Barrett reducer: valid/ready in, valid/ready out,
// each carrying a sideband tag that travels with its operand.
interface barrett_reduce_pipe_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned QW    = 16,
  parameter int unsigned TAG_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [QW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reducer: out = in mod Q, fully reduced, with a single global
// advance so every stage holds together under backpressure.
module barrett_reduce_pipe #(
  parameter int unsigned     Q     = 3329,
  parameter int unsigned     QW    = 16,
  parameter int unsigned     DW    = 32,
  parameter int unsigned     K     = 32,
  parameter longint unsigned MU    = (64'd1 << K) / Q,
  parameter int unsigned     TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  barrett_reduce_pipe_if.slave  bus
);

  localparam int unsigned PW = DW + K;
  localparam int unsigned RW = QW + 2;

  if (K >= 64) begin : g_bad_k
    $error("barrett_reduce_pipe: K must be below 64");
  end
  if (DW > K) begin : g_bad_dw
    $error("barrett_reduce_pipe: DW must not exceed K");
  end
  if (64'(Q) >= (64'd1 << QW) || Q < 2) begin : g_bad_q_range
    $error("barrett_reduce_pipe: Q must satisfy 2 <= Q < 2^QW");
  end
  if ((Q % 2) == 0) begin : g_bad_q_even
    $error("barrett_reduce_pipe: Q must be odd");
  end
  if (MU != ((64'd1 << K) / 64'(Q))) begin : g_bad_mu
    $error("barrett_reduce_pipe: MU must equal floor(2^K / Q)");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("barrett_reduce_pipe: TAG_W must be at least 1");
  end

  localparam logic [K-1:0]  MU_K = K'(MU);
  localparam logic [RW-1:0] Q1   = RW'(64'(Q));
  localparam logic [RW-1:0] Q2   = RW'(64'(Q) * 64'd2);

  logic adv;

  // Only the bits consumed downstream are kept: c and t are needed modulo 2^RW,
  // since the true remainder c - t is below 3Q < 2^RW.
  logic             s1_v;
  logic [RW-1:0]    s1_c;
  logic [DW-1:0]    s1_qh;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_v;
  logic [RW-1:0]    s2_c;
  logic [RW-1:0]    s2_t;
  logic [TAG_W-1:0] s2_tag;

  logic             s3_v;
  logic [QW-1:0]    s3_data;
  logic [TAG_W-1:0] s3_tag;

  logic [RW-1:0]    r;
  logic [RW-1:0]    r_red;

  assign adv          = bus.out_ready || !s3_v;
  assign bus.in_ready = adv;
  assign bus.out_valid = s3_v;
  assign bus.out_data  = s3_data;
  assign bus.out_tag   = s3_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_c   <= '0;
      s1_qh  <= '0;
      s1_tag <= '0;
    end else if (adv) begin
      s1_v   <= bus.in_valid;
      s1_c   <= RW'(bus.in_data);
      s1_qh  <= DW'((PW'(bus.in_data) * PW'(MU_K)) >> K);
      s1_tag <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_c   <= '0;
      s2_t   <= '0;
      s2_tag <= '0;
    end else if (adv) begin
      s2_v   <= s1_v;
      s2_c   <= s1_c;
      s2_t   <= RW'((DW+1)'(s1_qh) * (DW+1)'(64'(Q)));
      s2_tag <= s1_tag;
    end
  end

  assign r = s2_c - s2_t;

  // Quotient estimate can be short by up to two, hence the two-step correction.
  always_comb begin
    r_red = r;
    if (r >= Q2) begin
      r_red = r - Q2;
    end else if (r >= Q1) begin
      r_red = r - Q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v    <= 1'b0;
      s3_data <= '0;
      s3_tag  <= '0;
    end else if (adv) begin
      s3_v    <= s2_v;
      s3_data <= QW'(r_red);
      s3_tag  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Bench for barrett_reduce_pipe: default (Q=3329) and wide (Q=8380417, 48-bit) instances,
// checked against plain modulo arithmetic via expected-result queues.
module tb_barrett_reduce_pipe;

  localparam int unsigned Q_A = 3329;
  localparam int unsigned QW_A = 16;
  localparam int unsigned DW_A = 32;
  localparam int unsigned K_A = 32;
  localparam int unsigned Q_B = 8380417;
  localparam int unsigned QW_B = 24;
  localparam int unsigned DW_B = 48;
  localparam int unsigned K_B = 48;
  localparam longint unsigned MU_B = (64'd1 << 48) / 64'(Q_B);
  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barrett_reduce_pipe_if #(.DW(DW_A), .QW(QW_A), .TAG_W(TW)) bus_a ();
  barrett_reduce_pipe_if #(.DW(DW_B), .QW(QW_B), .TAG_W(TW)) bus_b ();

  barrett_reduce_pipe #(.Q(Q_A), .QW(QW_A), .DW(DW_A), .K(K_A), .TAG_W(TW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  barrett_reduce_pipe #(.Q(Q_B), .QW(QW_B), .DW(DW_B), .K(K_B), .MU(MU_B), .TAG_W(TW)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct {
    longint unsigned data;
    logic [TW-1:0]   tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int xfer_a = 0;
  int xfer_b = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for instance A: stall-hold, ready rule, ordering, tags.
  logic          prev_stall_a = 1'b0;
  logic [15:0]   prev_d_a = '0;
  logic [TW-1:0] prev_t_a = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qa.delete();
      prev_stall_a <= 1'b0;
    end else begin
      chk("a_in_ready_rule", bus_a.in_ready, bus_a.out_ready || !bus_a.out_valid);
      if (prev_stall_a) begin
        chk("a_hold_valid", bus_a.out_valid, 1);
        chk("a_hold_data", bus_a.out_data, prev_d_a);
        chk("a_hold_tag", bus_a.out_tag, prev_t_a);
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (qa.size() == 0) begin
          chk("a_spurious_out", qa.size(), 1);
        end else begin
          e = qa.pop_front();
          chk("a_out_data", bus_a.out_data, e.data);
          chk("a_out_tag", bus_a.out_tag, e.tag);
          xfer_a++;
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        e.data = 64'(bus_a.in_data) % 64'(Q_A);
        e.tag  = bus_a.in_tag;
        qa.push_back(e);
      end
      prev_stall_a <= bus_a.out_valid && !bus_a.out_ready;
      prev_d_a     <= bus_a.out_data;
      prev_t_a     <= bus_a.out_tag;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qb.delete();
    end else begin
      chk("b_in_ready_rule", bus_b.in_ready, bus_b.out_ready || !bus_b.out_valid);
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (qb.size() == 0) begin
          chk("b_spurious_out", qb.size(), 1);
        end else begin
          e = qb.pop_front();
          chk("b_out_data", bus_b.out_data, e.data);
          chk("b_out_tag", bus_b.out_tag, e.tag);
          xfer_b++;
        end
      end
      if (bus_b.in_valid && bus_b.in_ready) begin
        e.data = 64'(bus_b.in_data) % 64'(Q_B);
        e.tag  = bus_b.in_tag;
        qb.push_back(e);
      end
    end
  end

  // Called at posedge+1 with an empty pipe; checks exact 3-cycle latency.
  task automatic run_single(input logic [31:0] c, input logic [TW-1:0] tag, input int unsigned exp);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = c;
    bus_a.in_tag    = tag;
    chk("single_in_ready", bus_a.in_ready, 1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus_a.in_valid = 1'b0;
      chk("single_latency", bus_a.out_valid, (i == 3));
    end
    chk("single_data", bus_a.out_data, exp);
    chk("single_tag", bus_a.out_tag, tag);
    @(posedge clk); #1;
    chk("single_drain", bus_a.out_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int guard;
    logic [31:0] c;

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_tag = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_tag = '0; bus_b.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_data", bus_a.out_data, 0);
    chk("rst_out_tag", bus_a.out_tag, 0);
    chk("rst_b_out_valid", bus_b.out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", bus_a.in_ready, 1);

    run_single(32'd0, 8'h11, 0);
    run_single(32'd3329, 8'h22, 0);
    run_single(32'd6657, 8'h33, 3328);
    run_single(32'd6658, 8'h44, 0);
    run_single(32'hFFFF_FFFF, 8'h55, 1352);
    run_single(32'd11075584, 8'h66, 1);

    // Back-to-back stream, no backpressure.
    x0 = xfer_a;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = $urandom;
      bus_a.in_tag   = TW'($urandom);
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stream_count", xfer_a - x0, 1000);
    chk("stream_pending", qa.size(), 0);

    // Random backpressure, about 30% stalled.
    for (int i = 0; i < 2000; i++) begin
      bus_a.out_ready = ($urandom_range(0, 9) >= 3);
      bus_a.in_valid  = $urandom_range(0, 1) == 1;
      bus_a.in_data   = $urandom;
      bus_a.in_tag    = TW'($urandom);
      @(posedge clk); #1;
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    guard = 0;
    while (qa.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_drained", qa.size(), 0);

    // Reset with three results in flight.
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = $urandom;
      bus_a.in_tag   = TW'(8'hA0 + i);
      @(posedge clk); #1;
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    chk("mid_full_valid", bus_a.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus_a.out_valid, 0);
    chk("mid_rst_data", bus_a.out_data, 0);
    chk("mid_rst_tag", bus_a.out_tag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", bus_a.out_valid, 0);
    c = $urandom;
    run_single(c, 8'h5A, 32'(64'(c) % 64'(Q_A)));

    // Wide parameter set: corner operands then a random stream.
    x0 = xfer_b;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 48'hFFFF_FFFF_FFFF;
    bus_b.in_tag   = 8'h01;
    @(posedge clk); #1;
    bus_b.in_data  = 48'(64'(Q_B) * 64'(Q_B) - 64'd1);
    bus_b.in_tag   = 8'h02;
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      bus_b.in_data = {16'($urandom), 32'($urandom)};
      bus_b.in_tag  = TW'($urandom);
      @(posedge clk); #1;
    end
    bus_b.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b_stream_count", xfer_b - x0, 302);
    chk("b_stream_pending", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
